// File: rtl/processor_help.sv
// Shared fetch/decode types and sizing constants.
package processor_help;
  localparam int WORD_SIZE = 32;
  localparam int SUPER_SCALAR_WIDTH = 4;
  localparam int FETCH_BUFFER_DEPTH = 16;
  localparam int FETCH_MAX_OUTSTANDING = 2;

  typedef logic [WORD_SIZE-1:0] Word;

  typedef enum logic [1:0] {
    DEQUEUE  = 2'd0,
    STALL    = 2'd1,
    REDIRECT = 2'd2
  } FetchOperation;

  typedef struct packed {
    FetchOperation operation;
    Word           redirect_pc;
  } FetchRequest;

  typedef struct packed {
    Word pc;
    Word instruction;
  } FetchResult;
endpackage

// File: rtl/multi_port_fifo.sv
// Circular queue: WIDTH entries written per push,
// WIDTH oldest entries visible, variable pop count.
module multi_port_fifo
  import processor_help::*;
#(
  parameter type T = FetchResult,
  parameter int DEPTH = 16,
  parameter int WIDTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic                         wr_en_i,
  input  T [WIDTH-1:0]                 wr_data_i,
  input  logic [$clog2(WIDTH+1)-1:0]   pop_n_i,
  output T [WIDTH-1:0]                 rd_data_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  T mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    head_d  = head_q + PW'(pop_n_i);
    tail_d  = tail_q;
    count_d = count_q - CW'(pop_n_i);
    if (wr_en_i) begin
      tail_d  = tail_q + PW'(WIDTH);
      count_d = count_d + CW'(WIDTH);
    end
    if (flush_i) begin
      head_d  = tail_q;
      tail_d  = tail_q;
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_i && !flush_i)
      for (int i = 0; i < WIDTH; i++)
        mem_q[tail_q + PW'(i)] <= wr_data_i[i];
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_rd
    assign rd_data_o[g] = mem_q[head_q + PW'(g)];
  end

  assign count_o = count_q;
endmodule

// File: rtl/fetch_buffer.sv
// Fetch buffer: owns fetch PC, issues credited
// imem requests, queues groups for decode.
module fetch_buffer
  import processor_help::*;
#(
  parameter int  WIDTH = SUPER_SCALAR_WIDTH,
  parameter int  DEPTH = FETCH_BUFFER_DEPTH,
  parameter int  MAX_OUTSTANDING = FETCH_MAX_OUTSTANDING,
  parameter Word RESET_PC = '0
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  output logic                       imem_req_valid,
  input  logic                       imem_req_ready,
  output Word                        imem_req_pc,
  input  logic                       imem_resp_valid,
  input  logic [WIDTH*WORD_SIZE-1:0] imem_resp_data,
  input  FetchRequest                fetch_request,
  input  logic [$clog2(WIDTH+1)-1:0] deq_count,
  output logic [WIDTH-1:0]           out_valid,
  output FetchResult [WIDTH-1:0]     out_results
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int NW = $clog2(WIDTH+1);
  localparam int OW = $clog2(MAX_OUTSTANDING+1);
  localparam int FW =
    (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  function automatic logic [FW-1:0] pcf_inc(
    input logic [FW-1:0] p
  );
    return (p == FW'(MAX_OUTSTANDING-1)) ? '0 : p + FW'(1);
  endfunction

  Word fetch_pc_q, fetch_pc_d;
  logic [OW-1:0] outst_q, outst_d;
  logic [OW-1:0] drop_q, drop_d;
  Word pcf_q [MAX_OUTSTANDING];
  logic [FW-1:0] pcf_rd_q, pcf_rd_d;
  logic [FW-1:0] pcf_wr_q, pcf_wr_d;
  logic [CW-1:0] count;
  logic [31:0] used;
  logic accept, redirect, dropping, write;
  logic [NW-1:0] pop_n;
  FetchResult [WIDTH-1:0] wr_data;

  // in-flight groups reserve queue space before they return
  assign used = 32'(count) + 32'(outst_q) * 32'(WIDTH);
  assign imem_req_valid = rst_n_in
    && (outst_q < OW'(MAX_OUTSTANDING))
    && (used + 32'(WIDTH) <= 32'(DEPTH));
  assign imem_req_pc = fetch_pc_q;

  assign accept   = imem_req_valid && imem_req_ready;
  assign redirect = fetch_request.operation == REDIRECT;
  assign dropping = redirect || (drop_q != '0);
  assign write    = imem_resp_valid && !dropping;

  always_comb begin
    pop_n = '0;
    if (fetch_request.operation == DEQUEUE)
      pop_n = (CW'(deq_count) > count) ? NW'(count) : deq_count;
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    outst_d = outst_q + OW'(accept) - OW'(imem_resp_valid);
    drop_d = drop_q;
    pcf_rd_d = pcf_rd_q;
    pcf_wr_d = pcf_wr_q;
    if (accept) begin
      fetch_pc_d = fetch_pc_q + Word'(WIDTH);
      pcf_wr_d = pcf_inc(pcf_wr_q);
    end
    if (write)
      pcf_rd_d = pcf_inc(pcf_rd_q);
    if (imem_resp_valid && drop_q != '0)
      drop_d = drop_q - OW'(1);
    if (redirect) begin
      fetch_pc_d = fetch_request.redirect_pc;
      drop_d = outst_d;
      pcf_rd_d = '0;
      pcf_wr_d = '0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      fetch_pc_q <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
      pcf_rd_q   <= '0;
      pcf_wr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      pcf_rd_q   <= pcf_rd_d;
      pcf_wr_q   <= pcf_wr_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (accept && !redirect)
      pcf_q[pcf_wr_q] <= fetch_pc_q;
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    assign wr_data[g].pc = pcf_q[pcf_rd_q] + Word'(g);
    assign wr_data[g].instruction =
      imem_resp_data[g*WORD_SIZE +: WORD_SIZE];
    assign out_valid[g] = count > CW'(g);
  end

  multi_port_fifo #(
    .T(FetchResult),
    .DEPTH(DEPTH),
    .WIDTH(WIDTH)
  ) u_fifo (
    .clk_i(clk_in),
    .rst_ni(rst_n_in),
    .flush_i(redirect),
    .wr_en_i(write),
    .wr_data_i(wr_data),
    .pop_n_i(pop_n),
    .rd_data_o(out_results),
    .count_o(count)
  );

  a_no_overflow: assert property (
    @(posedge clk_in) disable iff (!rst_n_in)
    write |-> 32'(count) + 32'(WIDTH) <= 32'(DEPTH));

  a_deq_range: assert property (
    @(posedge clk_in) disable iff (!rst_n_in)
    (fetch_request.operation == DEQUEUE)
      |-> CW'(deq_count) <= count);
endmodule

// File: tb/tb_fetch_buffer.sv
// Randomized scoreboard bench for fetch_buffer
// against an epoch-based queue model.
module tb_fetch_buffer;
  import processor_help::*;

  localparam int W  = 4;
  localparam int D  = 16;
  localparam int MO = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid, req_ready, resp_valid;
  Word req_pc;
  logic [W*WORD_SIZE-1:0] resp_data;
  FetchRequest freq;
  logic [2:0] deq;
  logic [W-1:0] out_valid;
  FetchResult [W-1:0] out_res;

  always #5 clk = ~clk;

  fetch_buffer dut (
    .clk_in(clk),
    .rst_n_in(rst_n),
    .imem_req_valid(req_valid),
    .imem_req_ready(req_ready),
    .imem_req_pc(req_pc),
    .imem_resp_valid(resp_valid),
    .imem_resp_data(resp_data),
    .fetch_request(freq),
    .deq_count(deq),
    .out_valid(out_valid),
    .out_results(out_res)
  );

  typedef struct {
    Word pc;
    int unsigned epoch;
  } fly_t;

  FetchResult exp_q[$];
  fly_t fly_q[$];
  Word m_pc;
  int unsigned epoch;
  int nvec, nerr;
  bit mon_en;
  bit force100;

  function automatic bit m_req_valid();
    return fly_q.size() < MO &&
      exp_q.size() + fly_q.size() * W + W <= D;
  endfunction

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    if (mon_en && rst_n) begin
      chk("req_valid", 64'(req_valid), 64'(m_req_valid()));
      if (req_valid && m_req_valid())
        chk("req_pc", 64'(req_pc), 64'(m_pc));
      for (int i = 0; i < W; i++) begin
        chk("out_valid", 64'(out_valid[i]),
            64'(i < exp_q.size()));
        if (i < exp_q.size())
          chk("out_result", out_res[i], exp_q[i]);
      end
    end
  end

  task automatic step(int p_ready, int p_resp, int p_deq,
                      int p_redir, int max_deq, bit exact);
    bit acc, rsp, redir;
    int r, lim, n;
    Word rpc;
    fly_t f;
    @(negedge clk);
    acc = m_req_valid();
    req_ready = ($urandom_range(99) < p_ready);
    acc = acc && req_ready;
    rsp = fly_q.size() > 0 && ($urandom_range(99) < p_resp);
    resp_valid = rsp;
    resp_data = {$urandom, $urandom, $urandom, $urandom};
    r = $urandom_range(99);
    n = 0;
    redir = 1'b0;
    rpc = $urandom;
    if (r < p_redir) begin
      redir = 1'b1;
      case ($urandom_range(2))
        0: rpc = 32'h0000_0100;
        1: rpc = 32'hFFFF_FFF8;
        default: rpc = $urandom;
      endcase
      if (force100) rpc = 32'h0000_0100;
      freq.operation = REDIRECT;
      deq = 3'($urandom_range(4));
    end else if (r < p_redir + p_deq) begin
      lim = exp_q.size() < max_deq ? exp_q.size() : max_deq;
      n = exact ? lim : $urandom_range(lim, 0);
      freq.operation = DEQUEUE;
      deq = 3'(n);
    end else begin
      freq.operation = STALL;
      deq = 3'($urandom_range(4));
    end
    freq.redirect_pc = rpc;
    if (rsp) begin
      f = fly_q.pop_front();
      if (f.epoch == epoch && !redir)
        for (int i = 0; i < W; i++)
          exp_q.push_back('{pc: f.pc + Word'(i),
            instruction: resp_data[i*WORD_SIZE +: WORD_SIZE]});
    end
    repeat (n) void'(exp_q.pop_front());
    if (acc) begin
      fly_q.push_back('{pc: m_pc, epoch: epoch});
      m_pc = m_pc + Word'(W);
    end
    if (redir) begin
      exp_q.delete();
      m_pc = rpc;
      epoch++;
    end
  endtask

  task automatic do_reset(int cycles);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_req_valid", 64'(req_valid), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    exp_q.delete();
    fly_q.delete();
    m_pc = '0;
    epoch++;
    req_ready = 1'b0;
    resp_valid = 1'b0;
    freq.operation = STALL;
    repeat (cycles) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    req_ready = 1'b0;
    resp_valid = 1'b0;
    resp_data = '0;
    freq = '{operation: STALL, redirect_pc: '0};
    deq = '0;
    m_pc = '0;
    epoch = 0;
    nvec = 0;
    nerr = 0;
    mon_en = 1'b0;
    force100 = 1'b0;
    do_reset(3);
    mon_en = 1'b1;
    repeat (14) step(100, 100, 0, 0, 4, 1'b0);
    repeat (8) step(0, 100, 100, 0, 4, 1'b1);
    repeat (60) step(100, 100, 100, 0, 3, 1'b1);
    repeat (300) step(70, 60, 60, 0, 4, 1'b0);
    force100 = 1'b1;
    repeat (2) step(100, 0, 0, 0, 4, 1'b0);
    step(0, 0, 0, 100, 4, 1'b0);
    force100 = 1'b0;
    repeat (8) step(100, 100, 0, 0, 4, 1'b0);
    repeat (800) step(80, 70, 50, 8, 4, 1'b0);
    repeat (200) step(100, 90, 30, 25, 4, 1'b0);
    repeat (2) step(100, 0, 0, 0, 4, 1'b0);
    do_reset(2);
    repeat (40) step(100, 100, 50, 0, 4, 1'b0);
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end
endmodule
